// File: rtl/mipi_csi_rx_lane_aligner.sv
// CSI-2 RX lane deskew: measures per-lane valid skew at packet start
// and re-times every active lane through a tapped delay line.
module mipi_csi_rx_lane_aligner #(
  parameter int ALIGN_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [2:0]      active_lanes_i,
  input  logic [3:0]      data_valid_i,
  input  logic [3:0][7:0] data_i,
  output logic [3:0]      data_valid_o,
  output logic [3:0][7:0] data_o,
  output logic            err_skew_o
);

  localparam int CW = $clog2(ALIGN_DEPTH) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ALIGNED = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam logic [CW-1:0] C_MAX = CW'(ALIGN_DEPTH);
  localparam logic [CW-1:0] C_ERR = CW'(ALIGN_DEPTH - 1);

  logic [1:0]                       r_state;
  logic [1:0]                       w_state_nxt;
  logic [3:0]                       r_mask;
  logic [3:0][ALIGN_DEPTH-1:0][8:0] r_dl;
  logic [3:0][CW-1:0]               r_cnt;
  logic [3:0][CW-1:0]               r_tap;
  logic                             r_err;

  logic [3:0]      w_cfg_mask;
  logic [3:0]      w_mask;
  logic [3:0]      w_act;
  logic            w_any;
  logic            w_all;
  logic            w_hit;
  logic            w_over;
  logic [3:0][8:0] w_tap;
  logic [3:0]      w_tv;
  logic            w_tv_any;
  logic            w_err;
  logic            w_latch;
  logic            w_zero_tap;
  logic            w_clr;
  logic            w_cnt_en;

  always_comb begin
    case (active_lanes_i)
      3'd1:    w_cfg_mask = 4'b1000;
      3'd2:    w_cfg_mask = 4'b1100;
      3'd4:    w_cfg_mask = 4'b1111;
      default: w_cfg_mask = 4'b0000;
    endcase
  end

  // IDLE decides on the live configuration; later states use the latched one
  assign w_mask = (r_state == S_IDLE) ? w_cfg_mask : r_mask;
  assign w_act  = data_valid_i & w_mask;
  assign w_any  = |w_act;
  assign w_all  = w_any && (w_act == w_mask);

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_act[k] && (r_cnt[k] >= C_ERR)) w_hit = 1'b1;
    end
  end

  assign w_over = w_hit && (w_act != w_mask);

  always_comb begin
    w_tap = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < ALIGN_DEPTH; j++) begin
        if (r_tap[k] == CW'(j)) w_tap[k] = r_dl[k][j];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_tv[k] = w_tap[k][8];
  end

  assign w_tv_any = |(w_tv & r_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_latch     = 1'b0;
    w_zero_tap  = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_all) begin
          w_state_nxt = S_ALIGNED;
          w_zero_tap  = 1'b1;
        end else if (w_any) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_all) begin
          w_state_nxt = S_ALIGNED;
          w_latch     = 1'b1;
        end else if (w_over) begin
          w_state_nxt = S_DRAIN;
          w_err       = 1'b1;
        end else if (!w_any) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end
      end
      S_ALIGNED: begin
        if (!w_tv_any) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (data_valid_i == 4'b0000) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cnt_en = (r_state == S_IDLE) || (r_state == S_WAIT);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_dl    <= '0;
      r_cnt   <= '0;
      r_tap   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (r_state == S_IDLE) r_mask <= w_cfg_mask;
      for (int k = 0; k < 4; k++) begin
        r_dl[k][0] <= {data_valid_i[k], data_i[k]};
        for (int j = 1; j < ALIGN_DEPTH; j++) begin
          r_dl[k][j] <= r_dl[k][j-1];
        end
        if (!data_valid_i[k] || w_clr) begin
          r_cnt[k] <= '0;
        end else if (w_cnt_en && (r_cnt[k] != C_MAX)) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
      if (w_zero_tap) begin
        r_tap <= '0;
      end else if (w_latch) begin
        r_tap <= r_cnt;
      end
    end
  end

  always_comb begin
    data_valid_o = '0;
    data_o       = '0;
    for (int k = 0; k < 4; k++) begin
      if ((r_state == S_ALIGNED) && r_mask[k]) begin
        data_valid_o[k] = w_tap[k][8];
        data_o[k]       = w_tap[k][7:0];
      end
    end
  end

  assign err_skew_o = r_err;

endmodule

// File: tb/tb_mipi_csi_rx_lane_aligner.sv
// Directed bench for the CSI-2 RX lane aligner: skewed, single-lane,
// excess-skew, uneven-end, reset and invalid-config packets.
module tb_mipi_csi_rx_lane_aligner;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ALIGNED = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [2:0]      active_lanes_i;
  logic [3:0]      data_valid_i;
  logic [3:0][7:0] data_i;
  logic [3:0]      data_valid_o;
  logic [3:0][7:0] data_o;
  logic            err_skew_o;

  logic [3:0]      v_q [32];
  logic [3:0][7:0] d_q [32];
  logic [3:0]      ov  [32];
  logic [3:0][7:0] od  [32];
  logic            oe  [32];
  logic [1:0]      st  [32];

  int n_chk  = 0;
  int n_fail = 0;

  mipi_csi_rx_lane_aligner #(.ALIGN_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .active_lanes_i (active_lanes_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .data_valid_o   (data_valid_o),
    .data_o         (data_o),
    .err_skew_o     (err_skew_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    for (int c = 0; c < 32; c++) begin
      v_q[c] = '0;
      d_q[c] = '0;
    end
  endtask

  task automatic lane(input int k, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      v_q[s+i][k] = 1'b1;
      d_q[s+i][k] = 8'(16 + i);
    end
  endtask

  // obs[c] is sampled before in[c] is applied, so in[c] shows in obs[c+1]
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      ov[c] = data_valid_o;
      od[c] = data_o;
      oe[c] = err_skew_o;
      st[c] = dut.r_state;
      data_valid_i = v_q[c];
      data_i       = d_q[c];
    end
  endtask

  logic        acc_v;
  logic        acc_e;
  logic [31:0] acc_d;
  int          n_err;

  initial begin
    reset_n_i      = 1'b0;
    active_lanes_i = 3'd4;
    data_valid_i   = '0;
    data_i         = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(data_valid_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_err", 32'(err_skew_o), 0);
    chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // 4 lanes, lane 3 earliest by 3 cycles
    clr_q();
    active_lanes_i = 3'd4;
    lane(3, 0, 5);
    lane(2, 1, 5);
    lane(1, 2, 5);
    lane(0, 3, 5);
    run(16);
    chk("t1_pre", 32'(ov[3]), 0);
    for (int c = 4; c <= 8; c++) begin
      chk("t1_valid", 32'(ov[c]), 'hF);
      for (int k = 0; k < 4; k++) chk("t1_data", 32'(od[c][k]), 16 + c - 4);
    end
    chk("t1_post", 32'(ov[9]), 0);
    acc_e = 1'b0;
    for (int c = 0; c < 16; c++) acc_e |= oe[c];
    chk("t1_err", 32'(acc_e), 0);

    // 1 lane, garbage on lanes 0-2
    clr_q();
    active_lanes_i = 3'd1;
    for (int c = 0; c < 12; c++) begin
      v_q[c][2:0] = 3'(c);
      d_q[c][0]   = 8'(60 + c);
      d_q[c][1]   = 8'(90 + c);
      d_q[c][2]   = 8'(200 + c);
    end
    v_q[0][3] = 1'b1; d_q[0][3] = 8'hA5;
    v_q[1][3] = 1'b1; d_q[1][3] = 8'h5A;
    v_q[2][3] = 1'b1; d_q[2][3] = 8'hFF;
    run(16);
    chk("t2_pre", 32'(ov[0]), 0);
    for (int c = 1; c <= 3; c++) begin
      chk("t2_valid", 32'(ov[c]), 'h8);
      chk("t2_other", 32'(od[c][2:0]), 0);
    end
    chk("t2_d0", 32'(od[1][3]), 'hA5);
    chk("t2_d1", 32'(od[2][3]), 'h5A);
    chk("t2_d2", 32'(od[3][3]), 'hFF);
    chk("t2_post", 32'(ov[4]), 0);

    // 2 lanes, skew of 4 exceeds depth
    clr_q();
    active_lanes_i = 3'd2;
    lane(3, 0, 8);
    lane(2, 4, 8);
    run(20);
    chk("t3_err_at", 32'(oe[4]), 1);
    n_err = 0;
    acc_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_err += int'(oe[c]);
      acc_v |= |ov[c];
    end
    chk("t3_err_cnt", 32'(n_err), 1);
    chk("t3_no_valid", 32'(acc_v), 0);
    chk("t3_drain", 32'(st[12]), 32'(S_DRAIN));
    chk("t3_idle", 32'(st[13]), 32'(S_IDLE));

    // clean 2-lane packet after the error
    clr_q();
    lane(3, 0, 3);
    lane(2, 1, 3);
    run(12);
    chk("t3b_pre", 32'(ov[1]), 0);
    for (int c = 2; c <= 4; c++) begin
      chk("t3b_valid", 32'(ov[c]), 'hC);
      chk("t3b_d3", 32'(od[c][3]), 16 + c - 2);
      chk("t3b_d2", 32'(od[c][2]), 16 + c - 2);
      chk("t3b_lo", 32'(od[c][1:0]), 0);
    end
    chk("t3b_post", 32'(ov[5]), 0);

    // zero skew, lane 0 one byte short
    clr_q();
    active_lanes_i = 3'd4;
    lane(3, 0, 7);
    lane(2, 0, 7);
    lane(1, 0, 7);
    lane(0, 0, 6);
    run(14);
    for (int c = 1; c <= 6; c++) chk("t4_valid", 32'(ov[c]), 'hF);
    chk("t4_d6", 32'(od[6][0]), 16 + 5);
    chk("t4_short", 32'(ov[7]), 'hE);
    chk("t4_d7", 32'(od[7][3]), 16 + 6);
    chk("t4_end", 32'(ov[8]), 0);
    chk("t4_st8", 32'(st[8]), 32'(S_ALIGNED));
    chk("t4_st9", 32'(st[9]), 32'(S_IDLE));

    // reset asserted while aligned
    clr_q();
    lane(3, 0, 8);
    lane(2, 0, 8);
    lane(1, 0, 8);
    lane(0, 0, 8);
    run(4);
    chk("t5_before", 32'(data_valid_o), 'hF);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("t5_valid", 32'(data_valid_o), 0);
    chk("t5_data", 32'(data_o), 0);
    chk("t5_state", 32'(dut.r_state), 32'(S_IDLE));
    data_valid_i = '0;
    data_i       = '0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    clr_q();
    lane(3, 0, 4);
    lane(1, 1, 4);
    lane(0, 2, 4);
    lane(2, 2, 4);
    run(12);
    chk("t5_pre", 32'(ov[2]), 0);
    for (int c = 3; c <= 6; c++) begin
      chk("t5_valid_al", 32'(ov[c]), 'hF);
      for (int k = 0; k < 4; k++) chk("t5_data_al", 32'(od[c][k]), 16 + c - 3);
    end
    chk("t5_post", 32'(ov[7]), 0);
    chk("t5_tap0", 32'(dut.r_tap[0]), 0);
    chk("t5_tap1", 32'(dut.r_tap[1]), 1);
    chk("t5_tap2", 32'(dut.r_tap[2]), 0);
    chk("t5_tap3", 32'(dut.r_tap[3]), 2);

    // invalid lane count
    clr_q();
    active_lanes_i = 3'd3;
    lane(3, 0, 6);
    lane(2, 1, 6);
    lane(1, 0, 6);
    lane(0, 5, 6);
    run(16);
    acc_v = 1'b0;
    acc_e = 1'b0;
    acc_d = '0;
    for (int c = 0; c < 16; c++) begin
      acc_v |= |ov[c];
      acc_e |= oe[c];
      acc_d |= od[c];
    end
    chk("t6_valid", 32'(acc_v), 0);
    chk("t6_data", acc_d, 0);
    chk("t6_err", 32'(acc_e), 0);
    chk("t6_state", 32'(st[10]), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_lane_aligner.md
# mipi_csi_rx_lane_aligner

Deskews the per-lane byte streams coming out of the per-lane byte aligners, so that byte k of every active lane appears on the same clock cycle. It sits directly upstream of the CSI-2 protocol layer and drives that layer's `data_i` and `data_valid_i` inputs. Per-lane skew is measured from the rise of each lane's valid at packet start, and each lane is re-timed through a short delay line. Skew beyond the supported depth is flagged with an error pulse.

## Interface
- `ALIGN_DEPTH`, default 4: number of delay-line taps per lane. The tolerated inter-lane skew is 0..`ALIGN_DEPTH`-1 cycles.
- `clk_i`  in  1: byte clock; the only clock domain.
- `reset_n_i`  in  1: reset, asynchronous, active-low.
- `active_lanes_i`  in  3: number of active lanes, from the configuration register.
  - 1 maps to lane mask 4'b1000.
  - 2 maps to lane mask 4'b1100.
  - 4 maps to lane mask 4'b1111.
  - Any other value maps to mask 0.
- `data_valid_i`  in  1 x [4]: per-lane byte valid from the byte aligners.
- `data_i`  in  8 x [4]: per-lane bytes. Lane 3 is always populated.
- `data_valid_o`  out  1 x [4]: aligned valid to the protocol layer.
- `data_o`  out  8 x [4]: aligned bytes to the protocol layer.
- `err_skew_o`  out  1: one-cycle pulse when skew exceeds the supported range.

## Operation
- Lane mask:
  - Sampled from `active_lanes_i` on the IDLE->WAIT transition and held until the next return to IDLE.
  - Inactive lanes are ignored. Their outputs are 0 and their valid is 0.
- Delay line, per lane k:
  - `dl[k][0]` <= {`data_valid_i[k]`, `data_i[k]`} every cycle.
  - `dl[k][j]` <= `dl[k][j-1]` for j = 1..`ALIGN_DEPTH`-1.
  - The delay line shifts in all states.
- Per-lane skew counter `cnt[k]`, width clog2(`ALIGN_DEPTH`)+1:
  - Cleared when the raw `data_valid_i[k]` is low.
  - Otherwise increments each cycle while in IDLE or WAIT, saturating at `ALIGN_DEPTH`.
- State machine states: IDLE, WAIT, ALIGNED, DRAIN.
  - **IDLE.** If any active raw valid is high and all active raw valids are high, go to ALIGNED, with every tap = 0. If any active raw valid is high but not all, go to WAIT.
  - **WAIT.**
    - All active raw valids high: latch `tap[k]` = `cnt[k]` (value before this cycle's increment) and go to ALIGNED.
    - Else, any active `cnt[k]` reaches `ALIGN_DEPTH`-1 while another active lane is still low: pulse `err_skew_o` and go to DRAIN.
    - Else, all active raw valids low (a glitch): go to IDLE and clear the counters.
  - **ALIGNED.**
    - `data_o[k]` = byte field of `dl[k][tap[k]]`.
    - `data_valid_o[k]` = valid field of `dl[k][tap[k]]` AND mask[k].
    - Each lane ends individually, so lanes carrying one byte fewer at packet end simply drop valid earlier.
    - Go to IDLE when all active tapped valids are low.
  - **DRAIN.** Outputs are held invalid. Go to IDLE when all raw `data_valid_i` are low.
- Mask = 0 (invalid configuration): the block stays in IDLE, outputs stay 0 and no error is raised.
- Taps are never changed mid-packet.

## Timing
- Reset values: state = IDLE, all delay lines = 0, all counters and taps = 0, mask = 0, `data_o` = 0, `data_valid_o` = 0, `err_skew_o` = 0.
- Latency:
  - The latest-arriving lane's first byte appears at the output 1 cycle after it is presented.
  - A lane that is s cycles earlier appears 1+s cycles after it is presented.
  - All active lanes' first bytes appear on the same output cycle.
- Outputs are a registered-source mux. No combinational path runs from `data_i` to `data_o`.
- `err_skew_o` is registered and asserted exactly one cycle per offending packet.
- In the cycle of the ALIGNED->IDLE transition, new input valids are captured by the delay line. The next packet is detected from IDLE on the following cycle. The minimum supported inter-packet gap is 2 low cycles.
- Reset asserted mid-packet clears everything immediately (asynchronous). Output valid drops in the same cycle reset asserts.

## Test plan
- **4-lane skew.** 4 lanes; lanes 0..3 rise at T+3, T+2, T+1, T+0; each lane sends bytes 8'h10+n.
  - Required: from T+4 on, all `data_valid_o` are high together.
  - Required: `data_o[k]` = 8'h10, 8'h11, ... in lockstep on every lane.
  - Required: `err_skew_o` stays 0.
- **1 lane.** 1 lane (`active_lanes_i` = 1), lane 3 only, bytes A5, 5A, FF; lanes 0-2 are toggled with garbage.
  - Required: `data_valid_o` = 4'b1000 for 3 cycles starting 1 cycle after input.
  - Required: `data_o[3]` = A5, 5A, FF.
  - Required: the other lanes read 0.
- **Excess skew.** 2 lanes; lane 3 rises at T, lane 2 rises at T+4, with `ALIGN_DEPTH` = 4.
  - Required: `err_skew_o` is pulsed once, at T+4.
  - Required: no output valid for the whole packet.
  - Required: the block returns to IDLE after both raw valids are low.
  - Required: the next clean packet aligns correctly.
- **Uneven end.** 4 lanes with zero skew; 7 bytes on lanes 3, 2, 1 and 6 bytes on lane 0.
  - Required: lane 0's output valid drops 1 cycle before the others.
  - Required: the state returns to IDLE 1 cycle after the last tapped valid falls.
- **Reset mid-packet.** `reset_n_i` is pulled low during ALIGNED.
  - Required: all outputs are 0 immediately.
  - Required: after release, a packet with skew 0,1,0,2 aligns with taps 0,1,0,2.
- **Invalid configuration.** `active_lanes_i` = 3 with activity on all lanes.
  - Required: outputs stay 0.
  - Required: `err_skew_o` stays 0.
